// File: rtl/pmod_als_sequencer.sv
// Serial sequencer for an 8-bit ambient-light ADC on a 16-bit frame (PMOD ALS).
// Optional frame-format check enabled by defining PMODALS_FRAME_CHECK_EN.
//
//  state | meaning
//  IDLE  | waiting for start or period tick, CS high
//  SETUP | CS low, SCLK high, CLK_DIV cycles before the first low phase
//  SHIFT | 16 SCLK periods, sdo captured on each low-to-high transition
//  HOLD  | CS high quiet time, valid pulses on the first cycle
module pmod_als_sequencer #(
    parameter int CLK_DIV       = 13,
    parameter int SAMPLE_PERIOD = 100000,
    parameter int QUIET         = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       start,
    input  logic       sdo,
    output logic       cs,
    output logic       sclk,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
    output logic       err
);

    localparam int CNT_MAX = (CLK_DIV > QUIET) ? CLK_DIV : QUIET;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PER_W   = $clog2(SAMPLE_PERIOD);

    // Frame bits above 12 only matter to the format check.
`ifdef PMODALS_FRAME_CHECK_EN
    localparam int SR_W = 16;
`else
    localparam int SR_W = 13;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [3:0]        bit_cnt, bit_n;
    logic              phase, phase_n;
    logic [SR_W-1:0]   sr, sr_n;
    logic [7:0]        data_n;
    logic [PER_W-1:0]  per, per_n;
    logic              tick;
    logic              frame_done;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_n      = bit_cnt;
        phase_n    = phase;
        sr_n       = sr;
        data_n     = data;
        per_n      = per;
        tick       = 1'b0;
        frame_done = 1'b0;

        if (!en) begin
            per_n = PER_W'(SAMPLE_PERIOD - 1);
        end else if (per == '0) begin
            tick  = 1'b1;
            per_n = PER_W'(SAMPLE_PERIOD - 1);
        end else begin
            per_n = per - PER_W'(1);
        end

        case (state)
            IDLE: begin
                if (start || tick) begin
                    state_n = SETUP;
                    cnt_n   = CNT_W'(CLK_DIV - 1);
                    bit_n   = 4'd0;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_n = SHIFT;
                    cnt_n   = CNT_W'(CLK_DIV - 1);
                    phase_n = 1'b0;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            SHIFT: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else if (!phase) begin
                    // Rising SCLK: the ADC changed sdo on the previous falling edge.
                    cnt_n   = CNT_W'(CLK_DIV - 1);
                    phase_n = 1'b1;
                    sr_n    = {sr[SR_W-2:0], sdo};
                end else if (bit_cnt == 4'd15) begin
                    state_n    = HOLD;
                    cnt_n      = CNT_W'(QUIET - 1);
                    data_n     = sr[12:5];
                    frame_done = 1'b1;
                end else begin
                    cnt_n   = CNT_W'(CLK_DIV - 1);
                    phase_n = 1'b0;
                    bit_n   = bit_cnt + 4'd1;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Pin outputs are registered from next-state so SCLK/CS never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= 4'd0;
            phase   <= 1'b1;
            sr      <= '0;
            data    <= 8'd0;
            per     <= PER_W'(SAMPLE_PERIOD - 1);
            cs      <= 1'b1;
            sclk    <= 1'b1;
            busy    <= 1'b0;
            valid   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_n;
            phase   <= phase_n;
            sr      <= sr_n;
            data    <= data_n;
            per     <= per_n;
            cs      <= !(state_n == SETUP || state_n == SHIFT);
            sclk    <= !(state_n == SHIFT && !phase_n);
            busy    <= (state_n != IDLE);
            valid   <= frame_done;
        end
    end

`ifdef PMODALS_FRAME_CHECK_EN
    logic frame_bad;
    assign frame_bad = (sr[15:13] != 3'd0) || (sr[3:0] != 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (frame_done) begin
            err <= frame_bad;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pmod_als_sequencer.sv
// Bench for pmod_als_sequencer: directed scenarios plus random traffic, all
// outputs checked every cycle against a timeline model of the conversion.
module tb_pmod_als_sequencer;

    localparam int D     = 2;
    localparam int Q     = 4;
    localparam int SP    = 200;
    localparam int S0    = D;
    localparam int S1    = D + 32 * D;
    localparam int TOTAL = S1 + Q;
`ifdef PMODALS_FRAME_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, en, start, sdo;
    logic       cs, sclk, valid, busy, err;
    logic [7:0] data;

    pmod_als_sequencer #(.CLK_DIV(D), .SAMPLE_PERIOD(SP), .QUIET(Q)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .sdo(sdo),
        .cs(cs), .sclk(sclk), .data(data), .valid(valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic frame_bad(input logic [15:0] f);
        logic bad;
        bad = (f[15:13] != 3'd0) || (f[3:0] != 4'd0);
        return CHECK_EN && bad;
    endfunction

    // Model: t = cycles since busy rose (-1 when idle); run = en-high cycles.
    int          t = -1;
    int          run = 0;
    logic [15:0] cur_frame = 16'h0;
    logic [7:0]  m_data = 8'h0;
    logic        m_err = 1'b0;
    logic        use_fixed = 1'b0;
    logic [15:0] fixed_frame = 16'h0;

    always @(posedge clk) begin
        logic tk;
        tk = 1'b0;
        if (rst) begin
            t = -1; run = 0; m_data = 8'h0; m_err = 1'b0;
        end else begin
            if (!en) run = 0;
            else begin
                run++;
                if (run == SP) begin tk = 1'b1; run = 0; end
            end
            if (t >= 0) begin
                t++;
                if (t == S1) begin
                    m_data = cur_frame[12:5];
                    m_err  = frame_bad(cur_frame);
                end
                if (t == TOTAL) t = -1;
            end else if (start || tk) begin
                t = 0;
                cur_frame = use_fixed ? fixed_frame : 16'($urandom);
            end
        end
    end

    logic check_on = 1'b0;

    always @(negedge clk) begin
        if (check_on) begin
            logic e_busy, e_cs, e_sclk, e_valid;
            e_busy  = (t >= 0);
            e_cs    = !(t >= 0 && t < S1);
            e_sclk  = (t >= S0 && t < S1) ? (((t - S0) / D) % 2 == 1) : 1'b1;
            e_valid = (t == S1);
            chk("busy", busy, e_busy);
            chk("cs", cs, e_cs);
            chk("sclk", sclk, e_sclk);
            chk("valid", valid, e_valid);
            chk("data", data, m_data);
            chk("err", err, m_err);
        end
    end

    // ADC model on sdo plus observation statistics.
    int   cyc = 0, fall = 0, fall_total = 0, valid_cnt = 0, busy_cnt = 0;
    int   last_v = -1, iv_min = 1000000, iv_max = 0;
    int   gap_run = 0, gap_min = 1000000;
    logic seen_low = 1'b0;
    logic sclk_prev = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (valid) begin
            valid_cnt++;
            if (last_v >= 0) begin
                if (cyc - last_v < iv_min) iv_min = cyc - last_v;
                if (cyc - last_v > iv_max) iv_max = cyc - last_v;
            end
            last_v = cyc;
        end
        if (busy) busy_cnt++;
        if (cs) fall = 0;
        if (sclk_prev && !sclk) begin
            fall_total++;
            if (fall < 16) sdo = cur_frame[15 - fall];
            fall++;
        end
        sclk_prev = sclk;
        if (cs) gap_run++;
        else begin
            if (gap_run > 0 && seen_low && gap_run < gap_min) gap_min = gap_run;
            seen_low = 1'b1;
            gap_run = 0;
        end
    end

    task automatic clear_stats();
        fall_total = 0; valid_cnt = 0; busy_cnt = 0; last_v = -1;
        iv_min = 1000000; iv_max = 0; gap_min = 1000000; seen_low = 1'b0;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; start = 1'b0; sdo = 1'b0;
        wait_n(1);
        start = 1'b1;
        wait_n(2);
        check_on = 1'b1;
        chk("reset_cs", cs, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_data", data, 8'h00);
        start = 1'b0;
        rst = 1'b0;
        wait_n(3);

        // Single shot, nominal frame.
        use_fixed = 1'b1; fixed_frame = 16'h14A0;
        clear_stats();
        pulse_start();
        wait_n(TOTAL + 10);
        chk("t1_valid_cnt", valid_cnt, 1);
        chk("t1_busy_len", busy_cnt, 70);
        chk("t1_sclk_falls", fall_total, 16);
        chk("t1_data", data, 8'hA5);
        chk("t1_err", err, 1'b0);
        chk("t1_model_data", m_data, 8'hA5);

        // Bad frame format: data still loads.
        fixed_frame = 16'h94A0;
        clear_stats();
        pulse_start();
        wait_n(TOTAL + 10);
        chk("t2_data", data, 8'hA5);
        chk("t2_err", err, CHECK_EN);
        chk("t2_valid_cnt", valid_cnt, 1);

        // Start retriggered while busy is dropped.
        fixed_frame = 16'h0FF0;
        clear_stats();
        pulse_start();
        wait_n(9);
        pulse_start();
        wait_n(29);
        pulse_start();
        wait_n(TOTAL + 10);
        chk("t3_valid_cnt", valid_cnt, 1);
        chk("t3_data", data, 8'h7F);

        // Reset during bit 8 of SHIFT.
        fixed_frame = 16'h1FE0;
        clear_stats();
        pulse_start();
        wait_n(34);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_cs", cs, 1'b1);
        chk("t4_sclk", sclk, 1'b1);
        chk("t4_busy", busy, 1'b0);
        chk("t4_data", data, 8'h00);
        rst = 1'b0;
        wait_n(TOTAL);
        chk("t4_valid_cnt", valid_cnt, 0);

        // Continuous mode for exactly 1000 cycles.
        use_fixed = 1'b0;
        clear_stats();
        en = 1'b1;
        wait_n(1000);
        en = 1'b0;
        wait_n(150);
        chk("t5_conversions", valid_cnt, 5);
        chk("t5_iv_min", iv_min, 200);
        chk("t5_iv_max", iv_max, 200);
        chk("t5_cs_gap_ok", gap_min >= Q, 1'b1);

        // Start coincident with the first tick.
        clear_stats();
        en = 1'b1;
        wait_n(199);
        pulse_start();
        wait_n(100);
        en = 1'b0;
        wait_n(20);
        chk("t6_valid_cnt", valid_cnt, 1);
        chk("t6_busy_len", busy_cnt, 70);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 299) == 0) en = ~en;
            rst = ($urandom_range(0, 699) == 0);
            @(negedge clk);
        end
        start = 1'b0; rst = 1'b0; en = 1'b0;
        wait_n(TOTAL + 10);
        chk("end_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
